// File: rtl/sensor_conditioner_pkg.sv
// Shared constants, counter widths and plausibility FSM encodings for the
// float-switch sensor conditioner.
package sensor_conditioner_pkg;

   localparam int DEB_LEN_DEF   = 4;
   localparam int FAULT_LEN_DEF = 8;
   localparam int DEB_CNT_W     = 4;
   localparam int FAULT_CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULT   = 2'b10
   } state_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle: raw float-switch levels in, conditioned levels, fault
// flag and FSM debug state out.
interface sensor_conditioner_if;
   import sensor_conditioner_pkg::*;

   // Level signals only, no handshake: the raw inputs are free-running
   // asynchronous levels and the outputs are valid on every cycle.
   logic   I_raw;
   logic   S_raw;
   logic   I;
   logic   S;
   logic   fault;
   state_t dbg_state;

   modport master (output I_raw, output S_raw,
                   input  I, input S, input fault, input dbg_state);
   modport slave  (input  I_raw, input S_raw,
                   output I, output S, output fault, output dbg_state);
endinterface

// File: rtl/sensor_conditioner_debounce_filter.sv
// Two-flop synchronizer followed by a saturating run-length debouncer; the
// output only follows a level that has been stable for DEB_LEN cycles.
module debounce_filter
   import sensor_conditioner_pkg::*;
#(
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic R,
   input  logic d_raw,
   output logic q
);

   logic                 sync1_q, sync2_q;
   logic                 q_q, q_d;
   logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      q_d   = q_q;
      // Counter measures the current run of disagreement with the output.
      if (sync2_q != q_q) begin
         if (cnt_q == DEB_CNT_W'(DEB_LEN - 1)) begin
            q_d   = sync2_q;
            cnt_d = '0;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (R) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         q_q     <= 1'b0;
      end else begin
         sync1_q <= d_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces both float switches and latches a fault when the upper switch
// reads wet while the lower reads dry for FAULT_LEN consecutive cycles.
module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter int DEB_LEN   = DEB_LEN_DEF,
   parameter int FAULT_LEN = FAULT_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 R,
   sensor_conditioner_if.slave  bus
);

   logic                   filt_i, filt_s;
   logic                   implausible;
   state_t                 state_q;
   logic [FAULT_CNT_W-1:0] fcnt_q;
   logic                   fault_q;

   debounce_filter #(.DEB_LEN(DEB_LEN)) u_filt_i (
      .clk   (clk),
      .R     (R),
      .d_raw (bus.I_raw),
      .q     (filt_i)
   );

   debounce_filter #(.DEB_LEN(DEB_LEN)) u_filt_s (
      .clk   (clk),
      .R     (R),
      .d_raw (bus.S_raw),
      .q     (filt_s)
   );

   assign implausible = filt_s && !filt_i;

   // fcnt_q holds the number of consecutive implausible cycles seen so far.
   always_ff @(posedge clk) begin
      if (R) begin
         state_q <= ST_OK;
         fcnt_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_OK: begin
               if (implausible) begin
                  state_q <= ST_SUSPECT;
                  fcnt_q  <= FAULT_CNT_W'(1);
               end
            end
            ST_SUSPECT: begin
               if (!implausible) begin
                  state_q <= ST_OK;
                  fcnt_q  <= '0;
               end else if (fcnt_q == FAULT_CNT_W'(FAULT_LEN - 1)) begin
                  state_q <= ST_FAULT;
                  fcnt_q  <= '0;
                  fault_q <= 1'b1;
               end else begin
                  fcnt_q  <= fcnt_q + FAULT_CNT_W'(1);
               end
            end
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
            default: begin
               state_q <= ST_OK;
               fcnt_q  <= '0;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

   // Forcing both levels low makes the pump controller run both pumps.
   assign bus.I         = fault_q ? 1'b0 : filt_i;
   assign bus.S         = fault_q ? 1'b0 : filt_s;
   assign bus.fault     = fault_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: a history-window reference
// model feeds an expected queue that is compared every cycle, plus directed checks.
module tb_sensor_conditioner;
   import sensor_conditioner_pkg::*;

   localparam int DEB_LEN   = 4;
   localparam int FAULT_LEN = 8;

   logic clk = 1'b0;
   logic r   = 1'b1;
   always #5 clk = ~clk;

   sensor_conditioner_if bus_if ();

   sensor_conditioner #(.DEB_LEN(DEB_LEN), .FAULT_LEN(FAULT_LEN)) dut (
      .clk (clk),
      .R   (r),
      .bus (bus_if.slave)
   );

   int errors = 0;
   int checks = 0;

   logic [4:0] exp_q[$];

   // Reference model: bit 0 of each history is the most recent raw sample.
   logic [31:0] hist_i  = '0;
   logic [31:0] hist_s  = '0;
   logic        m_i     = 1'b0;
   logic        m_s     = 1'b0;
   logic        m_fault = 1'b0;
   int          m_cnt   = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // A level flips when the DEB_LEN synchronized samples all disagree with it.
   function automatic logic window_flips(input logic [31:0] h, input logic cur);
      logic flip;
      flip = 1'b1;
      for (int k = 1; k <= DEB_LEN; k++)
         if (h[k] == cur) flip = 1'b0;
      return flip;
   endfunction

   task automatic model_edge(input logic ri, input logic rs, input logic rr);
      if (rr) begin
         hist_i = '0; hist_s = '0;
         m_i = 1'b0; m_s = 1'b0; m_fault = 1'b0; m_cnt = 0;
      end else begin
         if (!m_fault) begin
            if (m_s && !m_i) begin
               m_cnt++;
               if (m_cnt == FAULT_LEN) m_fault = 1'b1;
            end else begin
               m_cnt = 0;
            end
         end
         if (window_flips(hist_i, m_i)) m_i = ~m_i;
         if (window_flips(hist_s, m_s)) m_s = ~m_s;
         hist_i = {hist_i[30:0], ri};
         hist_s = {hist_s[30:0], rs};
      end
   endtask

   function automatic logic [4:0] exp_word();
      state_t st;
      st = m_fault ? ST_FAULT : ((m_cnt != 0) ? ST_SUSPECT : ST_OK);
      return {st, m_fault, m_fault ? 1'b0 : m_s, m_fault ? 1'b0 : m_i};
   endfunction

   task automatic drive_cycle(input logic ri, input logic rs, input logic rr);
      logic [4:0] got;
      logic [4:0] exp;
      bus_if.I_raw = ri;
      bus_if.S_raw = rs;
      r            = rr;
      @(posedge clk);
      model_edge(ri, rs, rr);
      exp_q.push_back(exp_word());
      @(negedge clk);
      got = {bus_if.dbg_state, bus_if.fault, bus_if.S, bus_if.I};
      exp = exp_q.pop_front();
      check_val("sb_out", 32'(got), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int lows;
      int ri_edge, rs_edge;
      logic saw_susp;
      logic ri, rs, rr;
      int len;

      bus_if.I_raw = 1'b0;
      bus_if.S_raw = 1'b0;
      repeat (2) drive_cycle(1'b0, 1'b0, 1'b1);
      check_val("rst_out", {27'd0, bus_if.dbg_state, bus_if.fault, bus_if.S, bus_if.I}, 32'd0);

      // Clean step on I_raw
      k = 0;
      do begin
         drive_cycle(1'b1, 1'b0, 1'b0);
         k++;
      end while (bus_if.I !== 1'b1 && k < 20);
      check_val("i_rise_lat", k, DEB_LEN + 2);
      check_val("s_stays_0", bus_if.S, 0);
      repeat (4) drive_cycle(1'b1, 1'b0, 1'b0);

      // Short glitch is filtered; a DEB_LEN pulse passes with its own width
      lows = 0;
      for (int n = 0; n < 13; n++) begin
         drive_cycle((n < 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
         if (bus_if.I !== 1'b1) lows++;
      end
      check_val("glitch3_lows", lows, 0);
      lows = 0;
      for (int n = 0; n < 16; n++) begin
         drive_cycle((n < 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
         if (bus_if.I !== 1'b1) lows++;
      end
      check_val("pulse4_lows", lows, 4);
      check_val("pulse4_back", bus_if.I, 1);

      // Simultaneous rise on both inputs
      drive_cycle(1'b0, 1'b0, 1'b1);
      ri_edge = -1;
      rs_edge = -1;
      for (int n = 0; n < 12; n++) begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         if (bus_if.I === 1'b1 && ri_edge < 0) ri_edge = n;
         if (bus_if.S === 1'b1 && rs_edge < 0) rs_edge = n;
      end
      check_val("sim_rise_i", ri_edge, DEB_LEN + 1);
      check_val("sim_rise_s", rs_edge, DEB_LEN + 1);
      check_val("sim_state_ok", bus_if.dbg_state, ST_OK);

      // Implausible combination for FAULT_LEN-1 cycles: recovers
      saw_susp = 1'b0;
      for (int n = 0; n < 19; n++) begin
         drive_cycle((n < FAULT_LEN - 1) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         if (bus_if.dbg_state === ST_SUSPECT) saw_susp = 1'b1;
      end
      check_val("susp_seen", saw_susp, 1);
      check_val("susp7_fault", bus_if.fault, 0);
      check_val("susp7_state", bus_if.dbg_state, ST_OK);

      // Implausible combination for FAULT_LEN cycles: latches
      for (int n = 0; n < 20; n++)
         drive_cycle((n < FAULT_LEN) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      check_val("susp8_fault", bus_if.fault, 1);
      check_val("susp8_forced", {bus_if.S, bus_if.I}, 0);

      // Fault is absorbing until reset
      repeat (10) drive_cycle(1'b1, 1'b1, 1'b0);
      check_val("fault_hold", {bus_if.fault, bus_if.S, bus_if.I}, 3'b100);
      drive_cycle(1'b1, 1'b1, 1'b1);
      check_val("fault_rst", {27'd0, bus_if.dbg_state, bus_if.fault, bus_if.S, bus_if.I}, 32'd0);
      k = 0;
      do begin
         drive_cycle(1'b1, 1'b1, 1'b0);
         k++;
      end while (bus_if.I !== 1'b1 && k < 20);
      check_val("post_fault_lat", k, DEB_LEN + 2);

      // Reset during the third debounce cycle of an S rise
      drive_cycle(1'b0, 1'b0, 1'b1);
      repeat (4) drive_cycle(1'b0, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1);
      check_val("mid_deb_s", bus_if.S, 0);
      k = 0;
      do begin
         drive_cycle(1'b0, 1'b1, 1'b0);
         k++;
      end while (bus_if.S !== 1'b1 && k < 20);
      check_val("s_rise_lat", k, DEB_LEN + 2);

      // Random bursty stimulus with occasional resets
      drive_cycle(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 60; n++) begin
         ri  = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 10);
         for (int j = 0; j < len; j++) begin
            rr = ($urandom_range(0, 80) == 0);
            drive_cycle(ri, rs, rr);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
